// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle for alu_seq
// master = operand source and result sink, slave = the ALU.
interface alu_seq_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       func;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             overflow;
   logic             zero;
   logic             illegal;

   modport master (
      output in_valid, func, a, b, out_ready,
      input  in_ready, out_valid, result, cout, overflow, zero, illegal
   );

   modport slave (
      input  in_valid, func, a, b, out_ready,
      output in_ready, out_valid, result, cout, overflow, zero, illegal
   );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with valid/ready handshake on both sides
// Optional iterative shift-add multiply (func 8) is enabled by defining ALU_MUL_EN.
module alu_seq #(
   parameter int WIDTH = 4
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   alu_seq_if.slave s_if
);
   localparam int MSB = WIDTH - 1;

   typedef enum logic [1:0] {
`ifdef ALU_MUL_EN
      S_BUSY = 2'd2,
`endif
      S_IDLE = 2'd0,
      S_DONE = 2'd1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_ld_single;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic             w_add_ov;
   logic             w_sub_ov;
   logic [MSB:0]     w_res;
   logic             w_cout;
   logic             w_ov;
   logic             w_ill;
   logic [MSB:0]     r_result;
   logic             r_cout;
   logic             r_ov;
   logic             r_zero;
   logic             r_ill;

   assign w_accept = s_if.in_valid && (r_state == S_IDLE);

   assign w_add    = {1'b0, s_if.a} + {1'b0, s_if.b};
   assign w_sub    = {1'b0, s_if.a} + {1'b0, ~s_if.b} + (WIDTH+1)'(1);
   // Same-sign operands producing a different-sign result is exactly carry-in(MSB) ^ carry-out.
   assign w_add_ov = (s_if.a[MSB] == s_if.b[MSB]) && (w_add[MSB] != s_if.a[MSB]);
   assign w_sub_ov = (s_if.a[MSB] != s_if.b[MSB]) && (w_sub[MSB] != s_if.a[MSB]);

`ifdef ALU_MUL_EN
   localparam int CW = $clog2(WIDTH);

   logic                 w_is_mul;
   logic                 w_mul_last;
   logic [2*WIDTH-1:0]   w_acc_nxt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [MSB:0]         r_mplier;
   logic [CW-1:0]        r_cnt;

   assign w_is_mul    = (s_if.func == 4'd8);
   assign w_ld_single = w_accept && !w_is_mul;
   assign w_acc_nxt   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mul_last  = (r_state == S_BUSY) && (r_cnt == CW'(WIDTH - 1));
`else
   assign w_ld_single = w_accept;
`endif

   always_comb begin
      w_res  = '0;
      w_cout = 1'b0;
      w_ov   = 1'b0;
      w_ill  = 1'b0;
      case (s_if.func)
         4'd0: begin
            w_res  = w_add[MSB:0];
            w_cout = w_add[WIDTH];
            w_ov   = w_add_ov;
         end
         4'd1: begin
            w_res  = w_sub[MSB:0];
            w_cout = w_sub[WIDTH];
            w_ov   = w_sub_ov;
         end
         4'd2: w_res = ~s_if.a;
         4'd3: w_res = s_if.a & s_if.b;
         4'd4: w_res = s_if.a | s_if.b;
         4'd5: w_res = s_if.a ^ s_if.b;
         4'd6: w_res = {{(WIDTH-1){1'b0}}, w_sub[MSB] ^ w_sub_ov};
         4'd7: w_res = {{(WIDTH-1){1'b0}}, s_if.a == s_if.b};
`ifdef ALU_MUL_EN
         4'd8: w_ill = 1'b0;
`endif
         default: w_ill = 1'b1;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
`ifdef ALU_MUL_EN
               w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
`else
               w_state_nxt = S_DONE;
`endif
            end
         end
`ifdef ALU_MUL_EN
         S_BUSY: if (w_mul_last) w_state_nxt = S_DONE;
`endif
         S_DONE: if (s_if.out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ov     <= 1'b0;
         r_zero   <= 1'b0;
         r_ill    <= 1'b0;
      end else if (w_ld_single) begin
         r_result <= w_res;
         r_cout   <= w_cout;
         r_ov     <= w_ov;
         r_zero   <= (w_res == '0);
         r_ill    <= w_ill;
`ifdef ALU_MUL_EN
      end else if (w_mul_last) begin
         r_result <= w_acc_nxt[MSB:0];
         r_cout   <= |w_acc_nxt[2*WIDTH-1:WIDTH];
         r_ov     <= 1'b0;
         r_zero   <= (w_acc_nxt[MSB:0] == '0);
         r_ill    <= 1'b0;
`endif
      end
   end

`ifdef ALU_MUL_EN
   // One partial product per BUSY cycle: multiplicand shifts left, multiplier shifts right.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (w_accept && w_is_mul) begin
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, s_if.a};
         r_mplier <= s_if.b;
         r_cnt    <= '0;
      end else if (r_state == S_BUSY) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
      end
   end
`endif

   assign s_if.in_ready  = (r_state == S_IDLE);
   assign s_if.out_valid = (r_state == S_DONE);
   assign s_if.result    = r_result;
   assign s_if.cout      = r_cout;
   assign s_if.overflow  = r_ov;
   assign s_if.zero      = r_zero;
   assign s_if.illegal   = r_ill;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (WIDTH=4 main instance, WIDTH=8 side instance)
// Covers both ALU_MUL_EN builds.
module tb_alu_seq;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_total = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_seq_if #(.WIDTH(W)) u_if ();
   alu_seq_if #(.WIDTH(8)) u_if8 ();

   alu_seq #(.WIDTH(W)) u_dut (.i_clk(clk), .i_rst_n(rst_n), .s_if(u_if));
   alu_seq #(.WIDTH(8)) u_dut8 (.i_clk(clk), .i_rst_n(rst_n), .s_if(u_if8));

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         o;
      logic         z;
      logic         il;
      int           lat;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [3:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                         input logic eo, input logic eil, input int lat);
      exp_t e;
      int   acc;
      bit   seen;
      e = '{r: er, c: ec, o: eo, z: (er == '0), il: eil, lat: lat};
      sb.push_back(e);
      @(negedge clk);
      for (int i = 0; i < 20 && !u_if.in_ready; i++) @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.func = f;
      u_if.a = a;
      u_if.b = b;
      @(posedge clk);
      #1;
      acc = cyc;
      u_if.in_valid = 1'b0;
      u_if.a = W'($urandom);
      u_if.b = W'($urandom);
      u_if.func = 4'($urandom);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (u_if.out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      e = sb.pop_front();
      if (seen) begin
         chk({tag, "_lat"}, cyc - acc + 1, e.lat);
         chk({tag, "_res"}, 32'(u_if.result), 32'(e.r));
         chk({tag, "_cout"}, 32'(u_if.cout), 32'(e.c));
         chk({tag, "_ov"}, 32'(u_if.overflow), 32'(e.o));
         chk({tag, "_zero"}, 32'(u_if.zero), 32'(e.z));
         chk({tag, "_ill"}, 32'(u_if.illegal), 32'(e.il));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      bit stale;
      u_if.in_valid = 1'b0;
      u_if.func = '0;
      u_if.a = '0;
      u_if.b = '0;
      u_if.out_ready = 1'b1;
      u_if8.in_valid = 1'b0;
      u_if8.func = '0;
      u_if8.a = '0;
      u_if8.b = '0;
      u_if8.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      u_if.in_valid = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(u_if.in_ready), 32'd1);
      chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
      chk("rst_result", 32'(u_if.result), 32'd0);
      chk("rst_zero", 32'(u_if.zero), 32'd0);
      u_if.in_valid = 1'b0;
      rst_n = 1'b1;

      run_op("add_7_1", 4'd0, 4'd7, 4'd1, 4'd8, 1'b0, 1'b1, 1'b0, 1);
      run_op("add_15_1", 4'd0, 4'd15, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1);
      run_op("sub_3_5", 4'd1, 4'd3, 4'd5, 4'd14, 1'b0, 1'b0, 1'b0, 1);
      run_op("sub_5_3", 4'd1, 4'd5, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 1);
      run_op("sub_8_1", 4'd1, 4'd8, 4'd1, 4'd7, 1'b1, 1'b1, 1'b0, 1);
      run_op("slt_m8_1", 4'd6, 4'd8, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1);
      run_op("slt_7_m1", 4'd6, 4'd7, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1);
      run_op("seq_5_5", 4'd7, 4'd5, 4'd5, 4'd1, 1'b0, 1'b0, 1'b0, 1);
      run_op("seq_5_6", 4'd7, 4'd5, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1);
      run_op("and", 4'd3, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0, 1);
      run_op("or", 4'd4, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0, 1);
      run_op("xor", 4'd5, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0, 1);
      run_op("not", 4'd2, 4'h5, 4'hF, 4'hA, 1'b0, 1'b0, 1'b0, 1);
      run_op("ill_12", 4'd12, 4'h3, 4'h4, 4'h0, 1'b0, 1'b0, 1'b1, 1);
`ifdef ALU_MUL_EN
      run_op("mul_7_3", 4'd8, 4'd7, 4'd3, 4'd5, 1'b1, 1'b0, 1'b0, W + 1);
      run_op("mul_2_3", 4'd8, 4'd2, 4'd3, 4'd6, 1'b0, 1'b0, 1'b0, W + 1);
      run_op("mul_15_15", 4'd8, 4'd15, 4'd15, 4'd1, 1'b1, 1'b0, 1'b0, W + 1);
`else
      run_op("mul_off", 4'd8, 4'd7, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1);
`endif

      // Backpressure: result held, in_ready low, new requests ignored until release.
      u_if.out_ready = 1'b0;
      run_op("bp_add", 4'd0, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1);
      u_if.in_valid = 1'b1;
      u_if.func = 4'd0;
      u_if.a = 4'd1;
      u_if.b = 4'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(u_if.out_valid), 32'd1);
         chk("bp_hold_res", 32'(u_if.result), 32'd5);
         chk("bp_hold_ready", 32'(u_if.in_ready), 32'd0);
      end
      u_if.in_valid = 1'b0;
      u_if.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel_ready", 32'(u_if.in_ready), 32'd1);
      chk("bp_rel_valid", 32'(u_if.out_valid), 32'd0);
      repeat (3) @(negedge clk);
      chk("bp_no_extra", 32'(u_if.out_valid), 32'd0);

      // Reset with an op in flight: nothing must emerge afterwards.
      @(negedge clk);
      u_if.in_valid = 1'b1;
`ifdef ALU_MUL_EN
      u_if.func = 4'd8;
      u_if.a = 4'd7;
      u_if.b = 4'd9;
`else
      u_if.out_ready = 1'b0;
      u_if.func = 4'd0;
      u_if.a = 4'd2;
      u_if.b = 4'd3;
`endif
      @(posedge clk);
      #1;
      u_if.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 32'(u_if.out_valid), 32'd0);
      chk("mrst_result", 32'(u_if.result), 32'd0);
      chk("mrst_flags", {28'd0, u_if.cout, u_if.overflow, u_if.zero, u_if.illegal}, 32'd0);
      chk("mrst_in_ready", 32'(u_if.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      u_if.out_ready = 1'b1;
      stale = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (u_if.out_valid) stale = 1'b1;
      end
      chk("mrst_no_stale", 32'(stale), 32'd0);
      chk("mrst_ready_after", 32'(u_if.in_ready), 32'd1);

      run_op("post_rst_add", 4'd0, 4'd4, 4'd4, 4'd8, 1'b0, 1'b1, 1'b0, 1);

      // Eight-bit instance: signed overflow at the 0x7F boundary.
      @(negedge clk);
      u_if8.in_valid = 1'b1;
      u_if8.func = 4'd0;
      u_if8.a = 8'h7F;
      u_if8.b = 8'h01;
      @(posedge clk);
      #1;
      u_if8.in_valid = 1'b0;
      @(negedge clk);
      chk("w8_valid", 32'(u_if8.out_valid), 32'd1);
      chk("w8_res", 32'(u_if8.result), 32'h80);
      chk("w8_ov", 32'(u_if8.overflow), 32'd1);
      chk("w8_cout", 32'(u_if8.cout), 32'd0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
